bcd_display_scan: RTL and testbench
===================================

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clocks each digit is shown; legal range 1..65535.
REQ-002 SHALL have parameter NDIGITS, fixed at 4: number of scanned BCD digits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: when high, scanning runs; when low, scanning freezes and the display goes dark.
REQ-006 SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-007 SHALL have port digits, input, 16 bits: four 4-bit BCD digits; [3:0] is digit 0 (least significant) and [15:12] is digit 3 (most significant); each field is driven directly by an upstream mod-10 counter Count output.
REQ-008 SHALL have port seg, output, 7 bits: active-high segments ordered {g,f,e,d,c,b,a}; registered.
REQ-009 SHALL have port an, output, 4 bits: one-hot, active-high digit select; an[i] selects digit i; registered.

Function
REQ-010 SHALL hold a prescaler that counts 0..SCAN_DIV-1 while enable=1, wrapping to 0 after SCAN_DIV-1.
REQ-011 SHALL hold a 2-bit digit index that advances 0->1->2->3->0 on the clock where the prescaler wraps.
REQ-012 SHALL, with SCAN_DIV=1, advance the index on every enabled clock.
REQ-013 SHALL capture digits into a 16-bit shadow register on the clock where the index wraps from 3 to 0.
REQ-014 SHALL ignore changes on digits between frame boundaries, so the display never shows a torn frame.
REQ-015 SHALL decode shadow digit values 0-9 to standard patterns: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
REQ-016 SHALL decode shadow digit values 10-15 to a dash (1000000).
REQ-017 SHALL, when blank_lz=1, blank digit i (i=3..1) if that digit and all more-significant digits are 0; a blanked digit drives seg=0 and an=0 for its slot.
REQ-018 SHALL never blank digit 0.
REQ-019 SHALL update seg and an one clock after the index or shadow state they reflect changes; latency is 1 cycle.
REQ-020 SHALL, when enable=0, hold the prescaler, index and shadow, and register seg=0, an=0 on the next clock.
REQ-021 SHALL, when enable returns to 1, resume from the held prescaler and index values without restarting the frame.
REQ-022 SHALL assert at most one bit of an in any cycle.

Reset
REQ-023 SHALL, while reset=1 and regardless of clk, clear the prescaler, index, shadow, seg and an to 0.
REQ-024 SHALL, on the first enabled clock after reset release, show digit 0 with shadow value 0: an=0001, seg=0111111.
REQ-025 SHALL, on reset asserted mid-frame, abandon the frame immediately and restart from index 0 with shadow 0.

Structure
REQ-026 SHALL take NBITS_COUNT (=4), the digit-count constant and the 7-segment pattern constants (including DASH) from the shared project package.
REQ-027 SHALL implement the digit-to-pattern decode as one combinational sub-module named bcd_to_7seg, reusable by other display stages.
REQ-028 SHALL keep the prescaler width derived from SCAN_DIV via $clog2, with a minimum of 1 bit.

Verification
REQ-029 SHALL verify: SCAN_DIV=4, enable=1, digits=16'h1234 held for 2 frames -> second frame shows an 0001/0010/0100/1000, each for 4 clocks, with seg patterns for 4, 3, 2, 1.
REQ-030 SHALL verify: blank_lz=1, digits=16'h0070 -> an[3] and an[2] slots dark, digit 1 shows 0000111, digit 0 shows 0111111; blank_lz=0 -> all four slots lit.
REQ-031 SHALL verify: digits changed from 16'h0009 to 16'h0000 mid-frame -> display keeps 9 until the 3->0 wrap, then shows 0.
REQ-032 SHALL verify: digit 0 set to 4'hB -> its slot shows 1000000.
REQ-033 SHALL verify: enable dropped at index 2, prescaler 1, for 10 clocks -> seg=0 and an=0 one clock later; on re-enable, index 2 resumes and is shown for the remaining 2 clocks.
REQ-034 SHALL verify: reset pulsed asynchronously between clock edges during index 3 -> all outputs read 0 immediately; after release, an=0001 and seg=0111111.

Source files
------------

// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the BCD display path: digit sizing and the
// active-high {g,f,e,d,c,b,a} segment patterns.
package bcd_display_scan_pkg;

  localparam int NBITS_COUNT = 4;
  localparam int NUM_DIGITS  = 4;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/bcd_display_scan_to_7seg.sv
// Combinational BCD digit to 7-segment decode; non-BCD codes render as a dash.
module bcd_to_7seg
  import bcd_display_scan_pkg::*;
(
  input  logic [NBITS_COUNT-1:0] bcd,
  output logic [6:0]             seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Multiplexed 4-digit BCD display scanner with frame-synchronous digit
// capture, leading-zero blanking and registered seg/an outputs.
module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int NDIGITS  = NUM_DIGITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           blank_lz,
  input  logic [NDIGITS*NBITS_COUNT-1:0] digits,
  output logic [6:0]                     seg,
  output logic [NDIGITS-1:0]             an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0]                    ps_q, ps_d;
  digit_idx_t                       idx_q, idx_d;
  logic [NDIGITS*NBITS_COUNT-1:0]   shadow_q, shadow_d;
  logic [6:0]                       seg_q, seg_d;
  logic [NDIGITS-1:0]               an_q, an_d;

  logic                             ps_wrap;
  logic [NBITS_COUNT-1:0]           cur_digit;
  logic [6:0]                       cur_seg;
  logic [NDIGITS-1:0]               blank;

  assign ps_wrap   = (ps_q == PS_MAX);
  assign cur_digit = shadow_q[{idx_q, 2'b00} +: NBITS_COUNT];

  bcd_to_7seg u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  // A digit is blanked only if it and every more-significant digit are zero.
  always_comb begin
    blank = '0;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      if (i == NDIGITS - 1)
        blank[i] = blank_lz && (shadow_q[i*NBITS_COUNT +: NBITS_COUNT] == '0);
      else
        blank[i] = blank[i+1] && (shadow_q[i*NBITS_COUNT +: NBITS_COUNT] == '0);
    end
  end

  always_comb begin
    ps_d     = ps_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (enable) begin
      ps_d = ps_wrap ? '0 : ps_q + PW'(1);
      if (ps_wrap) begin
        idx_d = idx_q + 2'd1;
        // New digits are taken only at the frame boundary to avoid torn frames.
        if (idx_q == 2'd3)
          shadow_d = digits;
      end
    end
  end

  always_comb begin
    seg_d = SEG_OFF;
    an_d  = '0;
    if (enable && !blank[idx_q]) begin
      seg_d = cur_seg;
      an_d  = NDIGITS'(1) << idx_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_q     <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      seg_q    <= '0;
      an_q     <= '0;
    end else begin
      ps_q     <= ps_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: table-driven frame vectors plus hand-written
// multi-cycle sequences, checked through an expected-value queue.
module tb_bcd_display_scan;

  localparam logic [6:0] P0 = 7'b0111111, P1 = 7'b0000110, P2 = 7'b1011011,
                         P3 = 7'b1001111, P4 = 7'b1100110, P5 = 7'b1101101,
                         P6 = 7'b1111101, P7 = 7'b0000111, P8 = 7'b1111111,
                         P9 = 7'b1101111, PD = 7'b1000000, PX = 7'b0000000;
  localparam logic [15:0] ALL_ON = 16'b1000_0100_0010_0001;

  logic        clk = 1'b0;
  logic        reset, enable, blank_lz;
  logic [15:0] digits;
  logic [6:0]  seg, seg1;
  logic [3:0]  an, an1;

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];

  typedef struct packed {
    logic [15:0] d;
    logic        blz;
    logic [27:0] segs;   // {slot3, slot2, slot1, slot0}
    logic [15:0] ans;    // {slot3, slot2, slot1, slot0}
  } vec_t;
  vec_t vecs[9];

  bcd_display_scan #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .blank_lz(blank_lz),
    .digits(digits), .seg(seg), .an(an)
  );

  bcd_display_scan #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .blank_lz(blank_lz),
    .digits(digits), .seg(seg1), .an(an1)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [10:0] got);
    logic [10:0] e;
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s: got seg=%b an=%b, want seg=%b an=%b",
               name, got[10:4], got[3:0], e[10:4], e[3:0]);
    end
  endtask

  // Expect the main DUT to show (es, ea) after the next rising edge.
  task automatic check(input string name, input logic [6:0] es, input logic [3:0] ea);
    exp_q.push_back({es, ea});
    @(posedge clk);
    #1;
    compare(name, {seg, an});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    #2;
    exp_q.push_back(11'd0);
    compare("reset_state", {seg, an});
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_slot(input string name, input logic [15:0] d, input int slot,
                            input int n);
    logic [6:0] p;
    case (d[slot*4 +: 4])
      4'd1: p = P1; 4'd2: p = P2; 4'd3: p = P3; 4'd4: p = P4;
      default: p = P0;
    endcase
    repeat (n) check(name, p, 4'b0001 << slot);
  endtask

  initial begin
    logic [6:0] exp1[8];
    reset    = 1'b1;
    enable   = 1'b0;
    blank_lz = 1'b0;
    digits   = 16'h0000;

    vecs[0] = '{16'h1234, 1'b0, {P1, P2, P3, P4}, ALL_ON};
    vecs[1] = '{16'h0070, 1'b1, {PX, PX, P7, P0}, 16'b0000_0000_0010_0001};
    vecs[2] = '{16'h0070, 1'b0, {P0, P0, P7, P0}, ALL_ON};
    vecs[3] = '{16'h000B, 1'b0, {P0, P0, P0, PD}, ALL_ON};
    vecs[4] = '{16'h5678, 1'b1, {P5, P6, P7, P8}, ALL_ON};
    vecs[5] = '{16'h0009, 1'b1, {PX, PX, PX, P9}, 16'b0000_0000_0000_0001};
    vecs[6] = '{16'h0000, 1'b1, {PX, PX, PX, P0}, 16'b0000_0000_0000_0001};
    vecs[7] = '{16'hF0A0, 1'b1, {PD, P0, PD, P0}, ALL_ON};
    vecs[8] = '{16'h0105, 1'b1, {PX, P1, P0, P5}, 16'b0000_0100_0010_0001};

    // Table: first frame loads the shadow, second frame is checked slot by slot.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      digits   = vecs[v].d;
      blank_lz = vecs[v].blz;
      enable   = 1'b1;
      idle(16);
      for (int s = 0; s < 4; s++)
        repeat (4) check($sformatf("vec%0d_slot%0d", v, s),
                         vecs[v].segs[s*7 +: 7], vecs[v].ans[s*4 +: 4]);
    end

    // Mid-frame digit change is held off until the 3->0 wrap.
    do_reset();
    digits   = 16'h0009;
    blank_lz = 1'b0;
    enable   = 1'b1;
    idle(16);
    repeat (2) check("tear_pre", P9, 4'b0001);
    digits = 16'h0000;
    repeat (2) check("tear_hold", P9, 4'b0001);
    for (int s = 1; s < 4; s++) repeat (4) check("tear_rest", P0, 4'b0001 << s);
    repeat (4) check("tear_new", P0, 4'b0001);

    // Enable dropped with two clocks of digit 2 still to go.
    do_reset();
    digits = 16'h1234;
    enable = 1'b1;
    idle(16);
    check_slot("en_s0", 16'h1234, 0, 4);
    check_slot("en_s1", 16'h1234, 1, 4);
    check_slot("en_s2a", 16'h1234, 2, 2);
    enable = 1'b0;
    repeat (10) check("en_dark", PX, 4'b0000);
    enable = 1'b1;
    check_slot("en_s2b", 16'h1234, 2, 2);
    check_slot("en_s3", 16'h1234, 3, 4);
    check_slot("en_wrap", 16'h1234, 0, 1);

    // Asynchronous reset in the middle of digit 3.
    do_reset();
    digits = 16'h1234;
    enable = 1'b1;
    idle(28);
    check("ar_slot3", P1, 4'b1000);
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(11'd0);
    compare("ar_async_clear", {seg, an});
    @(negedge clk);
    reset = 1'b0;
    check("ar_first", P0, 4'b0001);
    repeat (3) check("ar_slot0", P0, 4'b0001);
    check("ar_slot1", P0, 4'b0010);

    // SCAN_DIV=1: index advances every enabled clock.
    do_reset();
    digits = 16'h1234;
    enable = 1'b1;
    exp1 = '{P0, P0, P0, P0, P4, P3, P2, P1};
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({exp1[k], 4'b0001 << (k % 4)});
      @(posedge clk);
      #1;
      compare($sformatf("div1_k%0d", k), {seg1, an1});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
